// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared AXI-Lite to APB bridge constants, response codes and state encodings
package bridge_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int APB_ADDR_W = 16;
    localparam int DATA_W     = 32;
    localparam int STRB_W     = DATA_W / 8;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WCOLLECT = 3'd1;
    localparam logic [2:0] S_WBUSY    = 3'd2;
    localparam logic [2:0] S_WRESP    = 3'd3;
    localparam logic [2:0] S_RBUSY    = 3'd4;
    localparam logic [2:0] S_RRESP    = 3'd5;

    // An out-of-range address reports DECERR even when it is also misaligned.
    function automatic logic [1:0] decode_resp(input logic range_err, input logic align_err);
        if (range_err) begin
            return DECERR;
        end else if (align_err) begin
            return SLVERR;
        end
        return OKAY;
    endfunction

endpackage

// File: rtl/axi_addr_decode.sv
// rtl/axi_addr_decode.sv - combinational bridge address window and alignment check
module axi_addr_decode
    import bridge_pkg::*;
#(
    parameter logic [15:0] BASE_HI = 16'h4000
) (
    input  logic [AXI_ADDR_W-1:0] i_addr,
    output logic                  o_range_err,
    output logic                  o_align_err
);

    logic w_unused_mid;

    assign o_range_err  = (i_addr[31:16] != BASE_HI);
    assign o_align_err  = (i_addr[1:0] != 2'b00);
    assign w_unused_mid = ^i_addr[15:2];

endmodule

// File: rtl/axi_lite_slave_if.sv
// rtl/axi_lite_slave_if.sv - AXI-Lite slave front end feeding the bridge state machine
module axi_lite_slave_if
    import bridge_pkg::*;
#(
    parameter int          UD      = 1,
    parameter logic [15:0] BASE_HI = 16'h4000
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [AXI_ADDR_W-1:0] AWADDR,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_W-1:0]     WDATA,
    input  logic [STRB_W-1:0]     WSTRB,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [AXI_ADDR_W-1:0] ARADDR,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [DATA_W-1:0]     RDATA,
    output logic [1:0]            RRESP,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic                  avalidend,
    output logic                  dvalidend,
    output logic                  SLVERR_sign,
    output logic [APB_ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0]     pwdata,
    output logic [STRB_W-1:0]     pstrb,
    output logic                  pwrite,
    input  logic                  apb_done,
    input  logic                  apb_err,
    input  logic [DATA_W-1:0]     apb_rdata
);

    // The unit delay is a simulation-only artefact; synthesised registers carry none.
    if (UD > 0) begin : g_ud_zero_delay
    end

    logic [2:0] r_state;
    logic [1:0] r_err_code;

    logic       w_aw_range_err;
    logic       w_aw_align_err;
    logic       w_ar_range_err;
    logic       w_ar_align_err;
    logic       w_aw_err;
    logic       w_ar_err;
    logic [1:0] w_aw_code;
    logic [1:0] w_ar_code;
    logic       w_aw_hs;
    logic       w_w_hs;
    logic       w_ar_hs;
    logic       w_wr_both;
    logic       w_err_next;

    axi_addr_decode #(.BASE_HI(BASE_HI)) u_aw_decode (
        .i_addr      (AWADDR),
        .o_range_err (w_aw_range_err),
        .o_align_err (w_aw_align_err)
    );

    axi_addr_decode #(.BASE_HI(BASE_HI)) u_ar_decode (
        .i_addr      (ARADDR),
        .o_range_err (w_ar_range_err),
        .o_align_err (w_ar_align_err)
    );

    assign w_aw_err  = w_aw_range_err | w_aw_align_err;
    assign w_ar_err  = w_ar_range_err | w_ar_align_err;
    assign w_aw_code = decode_resp(w_aw_range_err, w_aw_align_err);
    assign w_ar_code = decode_resp(w_ar_range_err, w_ar_align_err);

    always_comb begin
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        ARREADY = 1'b0;
        case (r_state)
            S_IDLE: begin
                ARREADY = 1'b1;
                AWREADY = !ARVALID;
                WREADY  = !ARVALID;
            end
            S_WCOLLECT: begin
                AWREADY = !avalidend;
                WREADY  = !dvalidend;
            end
            default: ;
        endcase
    end

    assign w_aw_hs    = AWVALID & AWREADY;
    assign w_w_hs     = WVALID & WREADY;
    assign w_ar_hs    = ARVALID & ARREADY;
    assign w_wr_both  = (avalidend | w_aw_hs) & (dvalidend | w_w_hs);
    assign w_err_next = SLVERR_sign | (w_aw_hs & w_aw_err);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state     <= S_IDLE;
            r_err_code  <= OKAY;
            avalidend   <= 1'b0;
            dvalidend   <= 1'b0;
            SLVERR_sign <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            pwrite      <= 1'b0;
            BRESP       <= OKAY;
            BVALID      <= 1'b0;
            RDATA       <= '0;
            RRESP       <= OKAY;
            RVALID      <= 1'b0;
        end else begin
            // Write-channel captures only happen in S_IDLE/S_WCOLLECT, where the readies allow them.
            if (w_aw_hs) begin
                paddr     <= AWADDR[APB_ADDR_W-1:0];
                pwrite    <= 1'b1;
                avalidend <= 1'b1;
                if (w_aw_err) begin
                    SLVERR_sign <= 1'b1;
                    r_err_code  <= w_aw_code;
                end
            end
            if (w_w_hs) begin
                pwdata    <= WDATA;
                pstrb     <= WSTRB;
                dvalidend <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_ar_hs) begin
                        paddr  <= ARADDR[APB_ADDR_W-1:0];
                        pwrite <= 1'b0;
                        if (w_ar_err) begin
                            SLVERR_sign <= 1'b1;
                            RDATA       <= '0;
                            RRESP       <= w_ar_code;
                            RVALID      <= 1'b1;
                            r_state     <= S_RRESP;
                        end else begin
                            r_state <= S_RBUSY;
                        end
                    end else if (w_aw_hs || w_w_hs) begin
                        r_state <= (w_wr_both && !w_err_next) ? S_WBUSY : S_WCOLLECT;
                    end
                end
                S_WCOLLECT: begin
                    // Both flags already registered means the address failed decode: answer without APB.
                    if (avalidend && dvalidend) begin
                        if (SLVERR_sign) begin
                            BRESP   <= r_err_code;
                            BVALID  <= 1'b1;
                            r_state <= S_WRESP;
                        end else begin
                            r_state <= S_WBUSY;
                        end
                    end else if (w_wr_both && !w_err_next) begin
                        r_state <= S_WBUSY;
                    end
                end
                S_WBUSY: begin
                    if (apb_done) begin
                        BRESP   <= apb_err ? SLVERR : OKAY;
                        BVALID  <= 1'b1;
                        r_state <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (BREADY) begin
                        BVALID      <= 1'b0;
                        avalidend   <= 1'b0;
                        dvalidend   <= 1'b0;
                        SLVERR_sign <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                S_RBUSY: begin
                    if (apb_done) begin
                        RDATA   <= apb_rdata;
                        RRESP   <= apb_err ? SLVERR : OKAY;
                        RVALID  <= 1'b1;
                        r_state <= S_RRESP;
                    end
                end
                S_RRESP: begin
                    if (RREADY) begin
                        RVALID      <= 1'b0;
                        SLVERR_sign <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_if.sv
// tb/tb_axi_lite_slave_if.sv - table-driven scoreboard bench for axi_lite_slave_if
module tb_axi_lite_slave_if;
    import bridge_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic        avalidend;
    logic        dvalidend;
    logic        SLVERR_sign;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pwrite;
    logic        apb_done;
    logic        apb_err;
    logic [31:0] apb_rdata;

    always #5 ACLK = ~ACLK;

    axi_lite_slave_if #(.UD(1), .BASE_HI(16'h4000)) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .AWADDR      (AWADDR),
        .AWVALID     (AWVALID),
        .AWREADY     (AWREADY),
        .WDATA       (WDATA),
        .WSTRB       (WSTRB),
        .WVALID      (WVALID),
        .WREADY      (WREADY),
        .BRESP       (BRESP),
        .BVALID      (BVALID),
        .BREADY      (BREADY),
        .ARADDR      (ARADDR),
        .ARVALID     (ARVALID),
        .ARREADY     (ARREADY),
        .RDATA       (RDATA),
        .RRESP       (RRESP),
        .RVALID      (RVALID),
        .RREADY      (RREADY),
        .avalidend   (avalidend),
        .dvalidend   (dvalidend),
        .SLVERR_sign (SLVERR_sign),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .pwrite      (pwrite),
        .apb_done    (apb_done),
        .apb_err     (apb_err),
        .apb_rdata   (apb_rdata)
    );

    typedef struct {
        bit          is_read;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          dec_err;
        bit          apb_err;
        logic [31:0] apb_rdata;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        bit          is_read;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[9];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wait_aw_w();
        int  n;
        bit  aw_f;
        bit  w_f;
        n = 0;
        while ((AWVALID || WVALID) && n < 20) begin
            #1;
            aw_f = AWVALID && AWREADY;
            w_f  = WVALID && WREADY;
            @(posedge ACLK);
            #1;
            if (aw_f) AWVALID = 1'b0;
            if (w_f)  WVALID  = 1'b0;
            n++;
        end
        chk("aw_w_handshake_done", {30'd0, AWVALID, WVALID}, 32'd0);
        AWVALID = 1'b0;
        WVALID  = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        int n;
        bit f;
        ARADDR  = a;
        ARVALID = 1'b1;
        n = 0;
        f = 1'b0;
        while (!f && n < 20) begin
            #1;
            f = ARREADY;
            @(posedge ACLK);
            #1;
            n++;
        end
        chk("ar_handshake_done", f, 1);
        ARVALID = 1'b0;
    endtask

    task automatic apb_pulse(input bit err, input logic [31:0] rd);
        apb_err   = err;
        apb_rdata = rd;
        apb_done  = 1'b1;
        tick();
        apb_done  = 1'b0;
        apb_err   = 1'b0;
    endtask

    task automatic collect_b(output int waits);
        exp_t       e;
        logic [1:0] r0;
        waits = 0;
        while (!BVALID && waits < 50) begin
            tick();
            waits++;
        end
        chk("bvalid_seen", BVALID, 1);
        r0 = BRESP;
        repeat (3) begin
            tick();
            chk("bvalid_hold", BVALID, 1);
            chk("bresp_stable", BRESP, r0);
        end
        chk("b_scoreboard_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("b_kind", e.is_read, 0);
            chk("bresp", BRESP, e.resp);
        end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        chk("bvalid_clear", BVALID, 0);
        chk("flags_clear_after_b", {29'd0, avalidend, dvalidend, SLVERR_sign}, 0);
    endtask

    task automatic collect_r(output int waits);
        exp_t        e;
        logic [1:0]  r0;
        logic [31:0] d0;
        waits = 0;
        while (!RVALID && waits < 50) begin
            tick();
            waits++;
        end
        chk("rvalid_seen", RVALID, 1);
        r0 = RRESP;
        d0 = RDATA;
        repeat (2) begin
            tick();
            chk("rvalid_hold", RVALID, 1);
            chk("rdata_stable", RDATA, d0);
            chk("rresp_stable", RRESP, r0);
        end
        chk("r_scoreboard_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("r_kind", e.is_read, 1);
            chk("rresp", RRESP, e.resp);
            chk("rdata", RDATA, e.data);
        end
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        chk("rvalid_clear", RVALID, 0);
        chk("slverr_clear_after_r", SLVERR_sign, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int w;
        if (!v.is_read) begin
            exp_q.push_back('{1'b0, v.exp_resp, 32'd0});
            AWADDR  = v.addr;
            WDATA   = v.wdata;
            WSTRB   = v.wstrb;
            AWVALID = 1'b1;
            WVALID  = 1'b1;
            wait_aw_w();
            chk("w_flags", {30'd0, avalidend, dvalidend}, 32'd3);
            chk("w_paddr", paddr, {16'd0, v.addr[15:0]});
            chk("w_pwdata", pwdata, v.wdata);
            chk("w_pstrb", pstrb, {28'd0, v.wstrb});
            chk("w_pwrite", pwrite, 1);
            chk("w_slverr_sign", SLVERR_sign, v.dec_err);
            if (!v.dec_err) begin
                tick();
                tick();
                chk("w_no_bvalid_while_busy", BVALID, 0);
                apb_pulse(v.apb_err, 32'h0);
                collect_b(w);
                chk("w_bvalid_latency", w, 0);
            end else begin
                chk("w_decerr_bvalid_cycle1", BVALID, 0);
                collect_b(w);
                chk("w_decerr_bvalid_latency", w, 1);
            end
        end else begin
            exp_q.push_back('{1'b1, v.exp_resp, v.exp_rdata});
            send_ar(v.addr);
            chk("r_paddr", paddr, {16'd0, v.addr[15:0]});
            chk("r_pwrite", pwrite, 0);
            chk("r_slverr_sign", SLVERR_sign, v.dec_err);
            if (!v.dec_err) begin
                chk("r_no_rvalid_while_busy", RVALID, 0);
                tick();
                tick();
                apb_pulse(v.apb_err, v.apb_rdata);
            end
            collect_r(w);
            chk("r_rvalid_latency", w, 0);
        end
    endtask

    initial begin
        int   w;
        vec_t v;

        vecs[0] = '{1'b0, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'h0,         OKAY,   32'h0};
        vecs[1] = '{1'b0, 32'h4000_0104, 32'h1234_ABCD, 4'h5, 1'b0, 1'b1, 32'h0,         SLVERR, 32'h0};
        vecs[2] = '{1'b0, 32'h5000_0000, 32'h1111_2222, 4'hF, 1'b1, 1'b0, 32'h0,         DECERR, 32'h0};
        vecs[3] = '{1'b0, 32'h4000_0003, 32'h3333_4444, 4'h1, 1'b1, 1'b0, 32'h0,         SLVERR, 32'h0};
        vecs[4] = '{1'b0, 32'h7000_0001, 32'h5555_6666, 4'h8, 1'b1, 1'b0, 32'h0,         DECERR, 32'h0};
        vecs[5] = '{1'b1, 32'h4000_0020, 32'h0,         4'h0, 1'b0, 1'b1, 32'h1234_5678, SLVERR, 32'h1234_5678};
        vecs[6] = '{1'b1, 32'h4000_0040, 32'h0,         4'h0, 1'b0, 1'b0, 32'hCAFE_F00D, OKAY,   32'hCAFE_F00D};
        vecs[7] = '{1'b1, 32'h4000_0002, 32'h0,         4'h0, 1'b1, 1'b0, 32'h0,         SLVERR, 32'h0};
        vecs[8] = '{1'b1, 32'h0000_0000, 32'h0,         4'h0, 1'b1, 1'b0, 32'h0,         DECERR, 32'h0};

        ARESETn   = 1'b0;
        AWADDR    = '0;
        AWVALID   = 1'b0;
        WDATA     = '0;
        WSTRB     = '0;
        WVALID    = 1'b0;
        BREADY    = 1'b0;
        ARADDR    = '0;
        ARVALID   = 1'b0;
        RREADY    = 1'b0;
        apb_done  = 1'b0;
        apb_err   = 1'b0;
        apb_rdata = '0;
        tick();
        tick();
        chk("rst_flags", {29'd0, avalidend, dvalidend, SLVERR_sign}, 0);
        chk("rst_valids", {30'd0, BVALID, RVALID}, 0);
        chk("rst_resps", {28'd0, BRESP, RRESP}, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_pstrb_pwrite", {27'd0, pstrb, pwrite}, 0);
        ARESETn = 1'b1;
        tick();
        chk("idle_readies", {29'd0, ARREADY, AWREADY, WREADY}, 32'd7);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
        end

        // W three cycles ahead of AW
        exp_q.push_back('{1'b0, OKAY, 32'd0});
        WDATA  = 32'h0BAD_F00D;
        WSTRB  = 4'h3;
        WVALID = 1'b1;
        #1;
        chk("wfirst_wready", WREADY, 1);
        tick();
        WVALID = 1'b0;
        chk("wfirst_flags", {30'd0, avalidend, dvalidend}, 32'd1);
        #1;
        chk("wfirst_readies", {30'd0, AWREADY, WREADY}, 32'd2);
        tick();
        tick();
        chk("wfirst_wait_flags", {30'd0, avalidend, dvalidend}, 32'd1);
        chk("wfirst_wait_wready", WREADY, 0);
        AWADDR  = 32'h4000_0048;
        AWVALID = 1'b1;
        wait_aw_w();
        chk("wfirst_both_flags", {30'd0, avalidend, dvalidend}, 32'd3);
        chk("wfirst_paddr", paddr, 32'h0048);
        chk("wfirst_pwdata", pwdata, 32'h0BAD_F00D);
        chk("wfirst_pstrb", pstrb, 32'h3);
        apb_pulse(1'b0, 32'h0);
        collect_b(w);
        chk("wfirst_bvalid_latency", w, 0);

        // AR and AW/W together in idle: read wins
        ARADDR  = 32'h4000_0030;
        ARVALID = 1'b1;
        AWADDR  = 32'h4000_0034;
        AWVALID = 1'b1;
        WDATA   = 32'h7777_8888;
        WSTRB   = 4'hF;
        WVALID  = 1'b1;
        exp_q.push_back('{1'b1, OKAY, 32'hA5A5_5A5A});
        exp_q.push_back('{1'b0, OKAY, 32'd0});
        #1;
        chk("prio_readies", {29'd0, ARREADY, AWREADY, WREADY}, 32'd4);
        tick();
        ARVALID = 1'b0;
        chk("prio_no_write_capture", {30'd0, avalidend, dvalidend}, 0);
        chk("prio_paddr", paddr, 32'h0030);
        #1;
        chk("prio_busy_readies", {30'd0, AWREADY, WREADY}, 0);
        tick();
        apb_pulse(1'b0, 32'hA5A5_5A5A);
        collect_r(w);
        wait_aw_w();
        chk("prio_write_paddr", paddr, 32'h0034);
        chk("prio_write_pwdata", pwdata, 32'h7777_8888);
        apb_pulse(1'b0, 32'h0);
        collect_b(w);

        // Reset while the write is waiting on APB
        AWADDR  = 32'h4000_0060;
        WDATA   = 32'h9999_0000;
        WSTRB   = 4'hF;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        wait_aw_w();
        tick();
        ARESETn = 1'b0;
        #1;
        chk("midrst_flags", {29'd0, avalidend, dvalidend, SLVERR_sign}, 0);
        chk("midrst_bvalid", BVALID, 0);
        chk("midrst_paddr", paddr, 0);
        chk("midrst_pwdata", pwdata, 0);
        chk("midrst_pwrite", pwrite, 0);
        tick();
        ARESETn = 1'b1;
        tick();
        apb_pulse(1'b0, 32'hFFFF_FFFF);
        chk("stray_done_ignored", {30'd0, BVALID, RVALID}, 0);
        v = '{1'b0, 32'h4000_0070, 32'h0102_0304, 4'hC, 1'b0, 1'b0, 32'h0, OKAY, 32'h0};
        run_vec(v);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/axi_lite_slave_if.md
# axi_lite_slave_if

AXI-Lite slave front end of the AXI-Lite to APB bridge, directly upstream of the bridge state machine. It accepts the AW, W and AR channels and latches address, data and strobes. It produces the `avalidend`, `dvalidend` and `SLVERR_sign` flags consumed by the bridge state machine, and returns B and R responses once the APB side reports completion. It allows one outstanding transaction at a time.

## Interface
Parameters:
- `UD`, 1: unit delay applied on every registered assignment.
- `BASE_HI`, 16'h4000: required value of `ADDR[31:16]` for a valid bridge access.

Ports. One clock; reset is asynchronous and active-low.
- `ACLK` in 1: bus clock; all logic on its rising edge.
- `ARESETn` in 1: asynchronous active-low reset.
- `AWADDR` in 32 / `AWVALID` in 1 / `AWREADY` out 1: write address channel.
- `WDATA` in 32 / `WSTRB` in 4 / `WVALID` in 1 / `WREADY` out 1: write data channel.
- `BRESP` out 2 / `BVALID` out 1 / `BREADY` in 1: write response channel.
- `ARADDR` in 32 / `ARVALID` in 1 / `ARREADY` out 1: read address channel.
- `RDATA` out 32 / `RRESP` out 2 / `RVALID` out 1 / `RREADY` in 1: read data channel.
- `avalidend` out 1: write address captured.
- `dvalidend` out 1: write data captured.
- `SLVERR_sign` out 1: the captured address fails decode.
- `paddr` out 16 / `pwdata` out 32 / `pstrb` out 4 / `pwrite` out 1: latched transfer fields for the APB driver.
- `apb_done` in 1: single-cycle pulse when the APB access ends (PREADY, PSLVERR or tout).
- `apb_err` in 1: valid with `apb_done`; high on PSLVERR or tout.
- `apb_rdata` in 32: PRDATA, valid with `apb_done`.

## Operation
- Internal FSM states: `S_IDLE`, `S_WCOLLECT`, `S_WBUSY`, `S_WRESP`, `S_RBUSY`, `S_RRESP`.
- Reset values: all outputs 0; `BRESP`/`RRESP` = OKAY (2'b00); state `S_IDLE`.
- **`S_IDLE`**
  - `ARREADY` = 1.
  - `AWREADY` = `WREADY` = !`ARVALID`, so a read has priority when it arrives in the same cycle as a write.
  - AR handshake: latch `ARADDR[15:0]` into `paddr`, clear `pwrite`, go to `S_RBUSY`. If decode fails, set `SLVERR_sign` and go to `S_RRESP` instead.
  - Any AW or W handshake: go to `S_WCOLLECT`.
- **`S_WCOLLECT`**
  - `AWREADY` = !`avalidend`; `WREADY` = !`dvalidend`; `ARREADY` = 0.
  - AW handshake: latch `paddr`, set `pwrite`, set `avalidend`.
  - W handshake: latch `pwdata`/`pstrb`, set `dvalidend`.
  - AW and W may arrive in either order or together, including the same cycle they arrive in `S_IDLE`.
  - Once both flags are set: go to `S_WBUSY`, or to `S_WRESP` if `SLVERR_sign` is set (no APB access is made).
- **Address decode**, combinational on the incoming address and registered on its handshake:
  - Out of range: `ADDR[31:16]` != `BASE_HI`.
  - Misaligned: `ADDR[1:0]` != 0.
  - Either condition sets `SLVERR_sign`.
  - Error response: DECERR (2'b11) if out of range, else SLVERR (2'b10); out of range wins when both hold.
- **`S_WBUSY` / `S_RBUSY`**
  - Wait for `apb_done`.
  - On write: `BRESP` = `apb_err` ? SLVERR : OKAY.
  - On read: `RDATA` = `apb_rdata`, `RRESP` = `apb_err` ? SLVERR : OKAY.
- **`S_WRESP`**
  - `BVALID` = 1 and held until `BREADY`.
  - On the handshake: clear `avalidend`, `dvalidend`, `SLVERR_sign` and `BVALID`; go to `S_IDLE`.
- **`S_RRESP`**
  - `RVALID` = 1 and held until `RREADY`.
  - On a decode-error read: `RDATA` = 0.
  - On the handshake: clear `SLVERR_sign` and `RVALID`; go to `S_IDLE`.
- `apb_done` outside `S_WBUSY`/`S_RBUSY` is ignored.
- `ARESETn` low mid-transaction: immediate return to reset values; the in-flight transaction is dropped with no response.

## Timing
- Flags, latched fields and `SLVERR_sign` are valid the cycle after the capturing handshake, as registered outputs.
- Ready signals are combinational from state and flags. No skid buffer, so READY may drop only after a handshake.
- Write with AW and W in the same cycle (handshake cycle 0):
  - Cycle 1: both flags set, state `S_WBUSY`.
  - `apb_done` in cycle N gives `BVALID` in N+1.
- Decode-error write: `BVALID` two cycles after the last of AW/W.
- Read: `ARREADY` handshake at cycle 0, `S_RBUSY` at 1; `RVALID` the cycle after `apb_done`.
- VALID/RESP/DATA remain stable while xVALID is high and xREADY is low.

## Structure
- Shared package `bridge_pkg`, used by this block and the bridge state machine:
  - `OKAY`/`EXOKAY`/`SLVERR`/`DECERR` codes.
  - AXI and APB address/data widths.
  - This block's state encodings.
- One combinational sub-module `axi_addr_decode` (address in, `BASE_HI` parameter → range-error and align-error bits). It is instantiated twice, once for AW and once for AR.

## Test plan
- Write 0x4000_0010 / 0xDEADBEEF, AW and W in the same cycle; `apb_done` with `apb_err`=0 three cycles later → `paddr`=0x0010, `pwdata`=0xDEADBEEF, `BRESP`=OKAY, `BVALID` held until a late `BREADY`.
- W three cycles before AW → `dvalidend` set first with `WREADY` low afterwards, then `avalidend`, then `S_WBUSY`; response OKAY.
- Read 0x4000_0020; `apb_done` with `apb_rdata`=0x12345678 and `apb_err`=1 → `RDATA`=0x12345678, `RRESP`=SLVERR.
- AWADDR 0x5000_0000 → `SLVERR_sign`=1, no `S_WBUSY`, `BRESP`=DECERR. ARADDR 0x4000_0002 → `RRESP`=SLVERR, `RDATA`=0.
- ARVALID and AWVALID together in idle → `AWREADY`=0 and the read completes first; the write is then accepted.
- `ARESETn` pulsed low during `S_WBUSY` → all outputs 0 immediately, state `S_IDLE`, and a following write completes normally.
